// File: rtl/pe_act_queue_pkg.sv
// Shared PE datapath widths and the activation token packing helper.
package pe_act_queue_pkg;

  localparam int unsigned PE_DATA_WIDTH      = 16;
  localparam int unsigned PE_ADDR_WIDTH      = 8;
  localparam int unsigned PE_QUEUE_WIDTH     = PE_ADDR_WIDTH + PE_DATA_WIDTH;
  localparam int unsigned PE_ACT_QUEUE_DEPTH = 8;

  typedef logic [PE_DATA_WIDTH-1:0]  pe_data_t;
  typedef logic [PE_ADDR_WIDTH-1:0]  pe_addr_t;
  typedef logic [PE_QUEUE_WIDTH-1:0] pe_queue_t;

  // Index occupies the MSBs of a queue entry.
  function automatic pe_queue_t pe_pack(input pe_addr_t idx, input pe_data_t value);
    return {idx, value};
  endfunction

endpackage

// File: rtl/pe_act_queue_mem.sv
// Register-file storage for the activation queue: one write port, one async read port.
module pe_act_queue_mem #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 24
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Contents are never reset; the top masks the read data while empty.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_act_queue.sv
// Per-PE input activation FIFO with optional zero-value skipping and first-word-fall-through head.
module pe_act_queue
  import pe_act_queue_pkg::*;
#(
  parameter int unsigned PE_IDX    = 0,
  parameter int unsigned DEPTH     = PE_ACT_QUEUE_DEPTH,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PE_ADDR_WIDTH-1:0]  in_idx,
  input  logic [PE_DATA_WIDTH-1:0]  in_value,
  output logic                      queue_empty,
  output logic [PE_QUEUE_WIDTH-1:0] act_out,
  input  logic                      pop_act,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      almost_full,
  output logic                      underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            underflow_q, underflow_d;

  logic            empty, ready;
  logic            fire, skip_zero, push_stored, pop_done;
  pe_queue_t       rd_data;

  // Status flags decode registered state only, so no input reaches them combinationally.
  assign empty = (count_q == '0);
  assign ready = (count_q != CntW'(DEPTH));

  assign fire        = in_valid & ready;
  assign skip_zero   = (ZERO_SKIP != 0) && (in_value == '0);
  assign push_stored = fire & ~skip_zero & ~flush;
  assign pop_done    = pop_act & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push_stored) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_done)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (pop_act && empty) underflow_d = 1'b1;
      count_d = count_q + CntW'(push_stored) - CntW'(pop_done);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  pe_act_queue_mem #(
    .Depth (DEPTH),
    .Width (PE_QUEUE_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_stored),
    .waddr_i (wr_ptr_q),
    .wdata_i (pe_pack(in_idx, in_value)),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign in_ready    = ready;
  assign queue_empty = empty;
  assign act_out     = empty ? '0 : rd_data;
  assign count       = count_q;
  assign almost_full = (count_q >= CntW'(AFULL_TH));
  assign underflow   = underflow_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(in_valid && in_ready && (count_q == CntW'(DEPTH))))
    else $error("pe_act_queue[%0d]: push accepted while full", PE_IDX);

endmodule

// File: tb/tb_pe_act_queue.sv
// Scoreboard bench for pe_act_queue: directed vectors, monitor compares each popped head entry.
module tb_pe_act_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid_b = 1'b0;
  logic        pop_act = 1'b0;
  logic        pop_b = 1'b0;
  logic [7:0]  in_idx = '0;
  logic [15:0] in_value = '0;

  logic        in_ready, queue_empty, almost_full, underflow;
  logic [23:0] act_out;
  logic [3:0]  count;
  logic        in_ready_b, queue_empty_b, almost_full_b, underflow_b;
  logic [23:0] act_out_b;
  logic [3:0]  count_b;

  int total = 0;
  int bad = 0;
  int n_pop_chk = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  pe_act_queue #(.PE_IDX(0), .DEPTH(8), .AFULL_TH(6), .ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_value(in_value), .queue_empty(queue_empty), .act_out(act_out),
    .pop_act(pop_act), .count(count), .almost_full(almost_full), .underflow(underflow)
  );

  pe_act_queue #(.PE_IDX(1), .DEPTH(8), .AFULL_TH(6), .ZERO_SKIP(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_idx(in_idx), .in_value(in_value), .queue_empty(queue_empty_b), .act_out(act_out_b),
    .pop_act(pop_b), .count(count_b), .almost_full(almost_full_b), .underflow(underflow_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: head compared on every accepted pop, then this cycle's stored push recorded.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (pop_act && !queue_empty) begin
        total++;
        n_pop_chk++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got=%0h want=none", act_out);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if (act_out !== e) begin
            bad++;
            $display("FAIL pop_data: got=%0h want=%0h", act_out, e);
          end
        end
      end
      if (in_valid && in_ready && in_value != 16'h0) exp_q.push_back({in_idx, in_value});
    end
  end

  task automatic cyc(input logic v, input logic vb, input logic [7:0] idx,
                     input logic [15:0] val, input logic pop, input logic fl);
    in_valid = v; in_valid_b = vb; in_idx = idx; in_value = val; pop_act = pop; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_b = 1'b0; pop_act = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check("rst_empty", {31'b0, queue_empty}, 1);
    check("rst_ready", {31'b0, in_ready}, 1);
    check("rst_count", {28'b0, count}, 0);
    check("rst_afull", {31'b0, almost_full}, 0);
    check("rst_underflow", {31'b0, underflow}, 0);
    check("rst_act_out", {8'b0, act_out}, 0);
    @(posedge clk); #1;

    // Fill to full, almost_full from the 6th entry, stall on a 9th.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 16'(i + 1), 1'b0, 1'b0);
      check("fill_afull", {31'b0, almost_full}, (i + 1 >= 6) ? 1 : 0);
    end
    check("fill_count", {28'b0, count}, 8);
    check("fill_ready", {31'b0, in_ready}, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 8'd8, 16'd9, 1'b0, 1'b0);
      check("stall_count", {28'b0, count}, 8);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    check("drain_empty", {31'b0, queue_empty}, 1);
    check("drain_underflow", {31'b0, underflow}, 0);

    // Zero skip on dut, zero stored on dut_b.
    cyc(1'b1, 1'b1, 8'd1, 16'd5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd2, 16'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'd3, 16'd7, 1'b0, 1'b0);
    check("zs_count", {28'b0, count}, 2);
    check("nozs_count", {28'b0, count_b}, 3);
    check("nozs_head", {8'b0, act_out_b}, 32'h01_0005);
    cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    check("nozs_flush", {28'b0, count_b}, 0);

    // Steady push+pop at occupancy 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i), 16'(10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, 8'(3 + k), 16'(13 + k), 1'b1, 1'b0);
      check("conc_count", {28'b0, count}, 3);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);

    // Underflow, empty push+pop, pop at full.
    cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    check("uf_set", {31'b0, underflow}, 1);
    check("uf_count", {28'b0, count}, 0);
    cyc(1'b1, 1'b0, 8'h50, 16'h55, 1'b1, 1'b0);
    check("empty_pp_count", {28'b0, count}, 1);
    check("empty_pp_uf", {31'b0, underflow}, 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(i), 16'(16'h60 + i), 1'b0, 1'b0);
    check("full2_count", {28'b0, count}, 8);
    pop_act = 1'b1;
    @(negedge clk);
    check("full_pop_ready_same", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    pop_act = 1'b0;
    check("full_pop_ready_next", {31'b0, in_ready}, 1);
    check("full_pop_count", {28'b0, count}, 7);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);

    // Flush with 5 entries and a concurrent push+pop.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(i), 16'(16'h70 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h9, 16'h99, 1'b1, 1'b1);
    check("flush_count", {28'b0, count}, 0);
    check("flush_uf", {31'b0, underflow}, 0);
    check("flush_empty", {31'b0, queue_empty}, 1);
    check("flush_act_out", {8'b0, act_out}, 0);
    cyc(1'b1, 1'b0, 8'h33, 16'h44, 1'b0, 1'b0);
    check("post_flush_head", {8'b0, act_out}, 32'h33_0044);
    cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i), 16'(16'h80 + i), 1'b0, 1'b0);
    in_valid = 1'b1; in_idx = 8'h7; in_value = 16'h77; pop_act = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_empty", {31'b0, queue_empty}, 1);
    check("mid_rst_ready", {31'b0, in_ready}, 1);
    check("mid_rst_count", {28'b0, count}, 0);
    check("mid_rst_act_out", {8'b0, act_out}, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; pop_act = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 8'h11, 16'h22, 1'b0, 1'b0);
    check("post_rst_count", {28'b0, count}, 1);
    cyc(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("sb_pop_checks", n_pop_chk, 44);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
